// File: rtl/rv32_mc_controller.sv
// Multi-cycle RV32I control unit: Moore FSM driving the shared datapath,
// memory handshake with bus timeout, and a sticky trap state.
module rv32_mc_controller #(
    parameter int TIMEOUT_CYC  = 255,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instruction,
    input  logic        i_mem_ready,
    input  logic        i_BrEq,
    input  logic        i_BrLt,
    output logic        PCWrite,
    output logic        PCSel,
    output logic        IRWrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic [2:0]  ImmSel,
    output logic        BrUn,
    output logic        ASel,
    output logic        BSel,
    output logic [3:0]  ALUSel,
    output logic        RegWEn,
    output logic [1:0]  WBSel,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } st_t;

    localparam int            CW    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam bit            TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CW-1:0] LIM   = CW'(TIMEOUT_CYC - 1);

    st_t           st;
    st_t           nxt;
    logic          taken;
    logic [CW-1:0] cnt;
    logic [1:0]    cause;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       b30;
    logic       unused_fields;

    assign opc           = i_instruction[6:0];
    assign f3            = i_instruction[14:12];
    assign f7            = i_instruction[31:25];
    assign b30           = i_instruction[30];
    assign unused_fields = ^{i_instruction[24:15], i_instruction[11:7]};

    logic r_lui, r_auipc, r_jal, r_jalr, r_br, r_ld, r_st, r_opi, r_op;
    logic opi_ok, op_ok, legal;
    logic k_lui, k_auipc, k_jal, k_jalr, k_br, k_ld, k_st, k_opi, k_op;
    logic [3:0] alu_f;
    logic br_cond;
    logic mem_busy, to_hit;

    // Instruction classification and legality
    always_comb begin
        r_lui   = (opc == 7'b0110111);
        r_auipc = (opc == 7'b0010111);
        r_jal   = (opc == 7'b1101111);
        r_jalr  = (opc == 7'b1100111);
        r_br    = (opc == 7'b1100011);
        r_ld    = (opc == 7'b0000011);
        r_st    = (opc == 7'b0100011);
        r_opi   = (opc == 7'b0010011);
        r_op    = (opc == 7'b0110011);
        if (f3 == 3'd1)      opi_ok = (f7 == 7'h00);
        else if (f3 == 3'd5) opi_ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                 opi_ok = 1'b1;
        op_ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
        legal = r_lui || r_auipc || r_jal
             || (r_jalr && f3 == 3'd0)
             || (r_br && f3[2:1] != 2'b01)
             || (r_ld && (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5))
             || (r_st && f3 <= 3'd2)
             || (r_opi && opi_ok)
             || (r_op && op_ok);
        k_lui   = r_lui   && legal;
        k_auipc = r_auipc && legal;
        k_jal   = r_jal   && legal;
        k_jalr  = r_jalr  && legal;
        k_br    = r_br    && legal;
        k_ld    = r_ld    && legal;
        k_st    = r_st    && legal;
        k_opi   = r_opi   && legal;
        k_op    = r_op    && legal;
    end

    // ALU function for OP/OP-IMM and branch condition
    always_comb begin
        case (f3)
            3'd0:    alu_f = (b30 && k_op) ? 4'd1 : 4'd0;
            3'd1:    alu_f = 4'd2;
            3'd2:    alu_f = 4'd3;
            3'd3:    alu_f = 4'd4;
            3'd4:    alu_f = 4'd5;
            3'd5:    alu_f = b30 ? 4'd7 : 4'd6;
            3'd6:    alu_f = 4'd8;
            default: alu_f = 4'd9;
        endcase
        case (f3)
            3'd0:      br_cond = i_BrEq;
            3'd1:      br_cond = !i_BrEq;
            3'd4, 3'd6: br_cond = i_BrLt;
            3'd5, 3'd7: br_cond = !i_BrLt;
            default:   br_cond = 1'b0;
        endcase
    end

    assign mem_busy = (st == S_FETCH || st == S_MEM) && !i_mem_ready;
    assign to_hit   = TO_EN && mem_busy && (cnt == LIM);

    // Next-state selection
    always_comb begin
        nxt = st;
        case (st)
            S_BOOT:   nxt = S_FETCH;
            S_FETCH:  nxt = i_mem_ready ? S_DECODE : (to_hit ? S_TRAP : S_FETCH);
            S_DECODE: nxt = legal ? S_EXEC : (ILLEGAL_TRAP ? S_TRAP : S_WB);
            S_EXEC:   nxt = (k_ld || k_st) ? S_MEM : S_WB;
            S_MEM:    nxt = i_mem_ready ? S_WB : (to_hit ? S_TRAP : S_MEM);
            S_WB:     nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_BOOT;
        endcase
    end

    // State, wait counter, branch outcome and trap cause registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st    <= S_BOOT;
            cnt   <= '0;
            taken <= 1'b0;
            cause <= 2'd0;
        end else begin
            st <= nxt;
            if (!TO_EN || !mem_busy || to_hit) cnt <= '0;
            else                               cnt <= cnt + CW'(1);
            if (st == S_EXEC && k_br) taken <= br_cond;
            else if (st == S_WB)      taken <= 1'b0;
            if (nxt == S_TRAP && st != S_TRAP)
                cause <= (st == S_DECODE) ? 2'd1 : 2'd2;
        end
    end

    // Moore outputs; EXEC fields also decode the held instruction
    always_comb begin
        PCWrite      = 1'b0;
        PCSel        = 1'b0;
        IRWrite      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_size     = 2'd0;
        mem_unsigned = 1'b0;
        ImmSel       = 3'd0;
        BrUn         = 1'b0;
        ASel         = 1'b0;
        BSel         = 1'b0;
        ALUSel       = 4'd0;
        RegWEn       = 1'b0;
        WBSel        = 2'd0;
        case (st)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_size = 2'd2;
                IRWrite  = i_mem_ready;
            end
            S_EXEC: begin
                unique case (1'b1)
                    k_op:    ALUSel = alu_f;
                    k_opi:   begin BSel = 1'b1; ImmSel = 3'd1; ALUSel = alu_f; end
                    k_ld:    begin BSel = 1'b1; ImmSel = 3'd1; end
                    k_st:    begin BSel = 1'b1; ImmSel = 3'd2; end
                    k_lui:   begin BSel = 1'b1; ImmSel = 3'd4; ALUSel = 4'd10; end
                    k_auipc: begin ASel = 1'b1; BSel = 1'b1; ImmSel = 3'd4; end
                    k_jal:   begin ASel = 1'b1; BSel = 1'b1; ImmSel = 3'd5; end
                    k_jalr:  begin BSel = 1'b1; ImmSel = 3'd1; end
                    k_br: begin
                        ASel   = 1'b1;
                        BSel   = 1'b1;
                        ImmSel = 3'd3;
                        BrUn   = f3[2] && f3[1];
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_we       = k_st;
                mem_size     = f3[1:0];
                mem_unsigned = f3[2];
            end
            S_WB: begin
                PCWrite = 1'b1;
                PCSel   = k_jal || k_jalr || (k_br && taken);
                RegWEn  = k_op || k_opi || k_lui || k_auipc || k_ld || k_jal || k_jalr;
                if (k_jal || k_jalr) WBSel = 2'd2;
                else if (k_ld)       WBSel = 2'd0;
                else if (RegWEn)     WBSel = 2'd1;
            end
            default: ;
        endcase
    end

    assign state      = st;
    assign trap       = (st == S_TRAP);
    assign trap_cause = cause;

endmodule

// File: tb/tb_rv32_mc_controller.sv
// Bench for rv32_mc_controller: directed cases plus randomized
// instructions checked cycle by cycle against a transaction-level model.
module tb_rv32_mc_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       trap;
        logic [1:0] cause;
        logic       pcw;
        logic       pcs;
        logic       irw;
        logic       req;
        logic       we;
        logic [1:0] sz;
        logic       uns;
        logic [2:0] imm;
        logic       brun;
        logic       asel;
        logic       bsel;
        logic [3:0] alu;
        logic       rwe;
        logic [1:0] wbs;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_instruction = '0;
    logic        i_mem_ready = 1'b0;
    logic        i_BrEq = 1'b0;
    logic        i_BrLt = 1'b0;

    logic a_pcw, a_pcs, a_irw, a_req, a_we, a_uns, a_brun, a_asel, a_bsel, a_rwe, a_trap;
    logic [1:0] a_sz, a_wbs, a_cause;
    logic [2:0] a_imm, a_st;
    logic [3:0] a_alu;
    logic b_pcw, b_pcs, b_irw, b_req, b_we, b_uns, b_brun, b_asel, b_bsel, b_rwe, b_trap;
    logic [1:0] b_sz, b_wbs, b_cause;
    logic [2:0] b_imm, b_st;
    logic [3:0] b_alu;

    exp_t obs_a, obs_b;
    assign obs_a = {a_st, a_trap, a_cause, a_pcw, a_pcs, a_irw, a_req, a_we, a_sz,
                    a_uns, a_imm, a_brun, a_asel, a_bsel, a_alu, a_rwe, a_wbs};
    assign obs_b = {b_st, b_trap, b_cause, b_pcw, b_pcs, b_irw, b_req, b_we, b_sz,
                    b_uns, b_imm, b_brun, b_asel, b_bsel, b_alu, b_rwe, b_wbs};

    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    rv32_mc_controller #(.TIMEOUT_CYC(4), .ILLEGAL_TRAP(1'b1)) u_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instruction(i_instruction),
        .i_mem_ready(i_mem_ready), .i_BrEq(i_BrEq), .i_BrLt(i_BrLt),
        .PCWrite(a_pcw), .PCSel(a_pcs), .IRWrite(a_irw), .mem_req(a_req),
        .mem_we(a_we), .mem_size(a_sz), .mem_unsigned(a_uns), .ImmSel(a_imm),
        .BrUn(a_brun), .ASel(a_asel), .BSel(a_bsel), .ALUSel(a_alu),
        .RegWEn(a_rwe), .WBSel(a_wbs), .state(a_st), .trap(a_trap),
        .trap_cause(a_cause)
    );

    rv32_mc_controller #(.TIMEOUT_CYC(0), .ILLEGAL_TRAP(1'b0)) u_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instruction(i_instruction),
        .i_mem_ready(i_mem_ready), .i_BrEq(i_BrEq), .i_BrLt(i_BrLt),
        .PCWrite(b_pcw), .PCSel(b_pcs), .IRWrite(b_irw), .mem_req(b_req),
        .mem_we(b_we), .mem_size(b_sz), .mem_unsigned(b_uns), .ImmSel(b_imm),
        .BrUn(b_brun), .ASel(b_asel), .BSel(b_bsel), .ALUSel(b_alu),
        .RegWEn(b_rwe), .WBSel(b_wbs), .state(b_st), .trap(b_trap),
        .trap_cause(b_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // one clock: drive ready at negedge, compare both DUTs 1 ns later
    task automatic cyc(input string tag, input exp_t ea, input exp_t eb, input logic rdy);
        @(negedge i_clk);
        i_mem_ready = rdy;
        #1;
        check({tag, "_a"}, 32'(obs_a), 32'(ea));
        check({tag, "_b"}, 32'(obs_b), 32'(eb));
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_mem_ready = 1'b0;
        #1;
        check("rst_a", 32'(obs_a), 32'(z));
        check("rst_b", 32'(obs_b), 32'(z));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("boot_a", 32'(obs_a), 32'(z));
        check("boot_b", 32'(obs_b), 32'(z));
    endtask

    // classes: 0 OP 1 OPIMM 2 LOAD 3 STORE 4 LUI 5 AUIPC 6 JAL 7 JALR 8 BRANCH
    function automatic logic [31:0] gen(input int cls);
        logic [31:0] r;
        logic [2:0]  lf [5];
        logic [2:0]  bf [6];
        logic        hi;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        r  = $urandom;
        hi = r[30];
        case (cls)
            0: begin
                r[6:0] = 7'b0110011;
                r[31:25] = ((r[14:12] == 3'd0 || r[14:12] == 3'd5) && hi) ? 7'h20 : 7'h00;
            end
            1: begin
                r[6:0] = 7'b0010011;
                if (r[14:12] == 3'd1) r[31:25] = 7'h00;
                else if (r[14:12] == 3'd5) r[31:25] = hi ? 7'h20 : 7'h00;
            end
            2: begin r[6:0] = 7'b0000011; r[14:12] = lf[$urandom_range(0, 4)]; end
            3: begin r[6:0] = 7'b0100011; r[14:12] = 3'($urandom_range(0, 2)); end
            4: r[6:0] = 7'b0110111;
            5: r[6:0] = 7'b0010111;
            6: r[6:0] = 7'b1101111;
            7: begin r[6:0] = 7'b1100111; r[14:12] = 3'd0; end
            default: begin r[6:0] = 7'b1100011; r[14:12] = bf[$urandom_range(0, 5)]; end
        endcase
        return r;
    endfunction

    function automatic exp_t exec_exp(input int cls, input logic [31:0] ins);
        exp_t e;
        int   tab [8];
        int   f3;
        tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3  = int'(ins[14:12]);
        e = '0;
        e.st = 3'd3;
        case (cls)
            0: e.alu = 4'((f3 == 0 && ins[30]) ? 1 : (f3 == 5 && ins[30]) ? 7 : tab[f3]);
            1: begin
                e.alu = 4'((f3 == 5 && ins[30]) ? 7 : tab[f3]);
                e.bsel = 1; e.imm = 3'd1;
            end
            2: begin e.bsel = 1; e.imm = 3'd1; end
            3: begin e.bsel = 1; e.imm = 3'd2; end
            4: begin e.bsel = 1; e.imm = 3'd4; e.alu = 4'd10; end
            5: begin e.asel = 1; e.bsel = 1; e.imm = 3'd4; end
            6: begin e.asel = 1; e.bsel = 1; e.imm = 3'd5; end
            7: begin e.bsel = 1; e.imm = 3'd1; end
            default: begin
                e.asel = 1; e.bsel = 1; e.imm = 3'd3;
                e.brun = (f3 >= 6);
            end
        endcase
        return e;
    endfunction

    function automatic logic br_taken(input int f3, input logic eq, input logic lt);
        case (f3)
            0:       return eq;
            1:       return !eq;
            4, 6:    return lt;
            default: return !lt;
        endcase
    endfunction

    // run one legal instruction with given fetch/memory wait counts
    task automatic run_ins(input int cls, input logic [31:0] ins, input int wf,
                           input int wm, input logic eq, input logic lt);
        exp_t e;
        logic tk;
        i_instruction = ins;
        i_BrEq = eq;
        i_BrLt = lt;
        e = '0; e.st = 3'd1; e.req = 1; e.sz = 2'd2;
        for (int k = 0; k < wf; k++) cyc("fetch_wait", e, e, 1'b0);
        e.irw = 1;
        cyc("fetch", e, e, 1'b1);
        e = '0; e.st = 3'd2;
        cyc("decode", e, e, 1'($urandom));
        e = exec_exp(cls, ins);
        cyc("exec", e, e, 1'($urandom));
        if (cls == 2 || cls == 3) begin
            e = '0; e.st = 3'd4; e.req = 1; e.we = (cls == 3);
            e.sz = ins[13:12]; e.uns = ins[14];
            for (int k = 0; k < wm; k++) cyc("mem_wait", e, e, 1'b0);
            cyc("mem", e, e, 1'b1);
        end
        tk = (cls == 8) && br_taken(int'(ins[14:12]), eq, lt);
        e = '0; e.st = 3'd5; e.pcw = 1;
        e.pcs = (cls == 6 || cls == 7 || tk);
        e.rwe = !(cls == 3 || cls == 8);
        e.wbs = (cls == 2) ? 2'd0 : (cls == 6 || cls == 7) ? 2'd2 : (e.rwe ? 2'd1 : 2'd0);
        cyc("wb", e, e, 1'($urandom));
    endtask

    initial begin
        exp_t ea, eb;
        do_reset();

        run_ins(0, 32'h002081B3, 0, 0, 1'b0, 1'b0);
        run_ins(2, 32'h0080A283, 0, 3, 1'b0, 1'b0);
        run_ins(8, 32'h00208463, 1, 0, 1'b1, 1'b0);
        run_ins(8, 32'h0020F463, 0, 0, 1'b0, 1'b1);
        run_ins(6, 32'h000000EF, 2, 0, 1'b0, 1'b0);
        run_ins(3, 32'h00508023, 3, 3, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            int cls;
            cls = $urandom_range(0, 8);
            run_ins(cls, gen(cls), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom));
        end

        // illegal instruction: trap on one DUT, NOP retire on the other
        i_instruction = 32'hFFFFFFFF;
        ea = '0; ea.st = 3'd1; ea.req = 1; ea.sz = 2'd2; ea.irw = 1;
        cyc("ill_fetch", ea, ea, 1'b1);
        ea = '0; ea.st = 3'd2;
        cyc("ill_decode", ea, ea, 1'b0);
        ea = '0; ea.st = 3'd6; ea.trap = 1; ea.cause = 2'd1;
        eb = '0; eb.st = 3'd5; eb.pcw = 1;
        cyc("ill_next", ea, eb, 1'b0);
        eb = '0; eb.st = 3'd1; eb.req = 1; eb.sz = 2'd2;
        for (int k = 0; k < 3; k++) cyc("ill_hold", ea, eb, 1'b0);
        do_reset();

        // bus timeout in FETCH: four wait cycles, then trap
        ea = '0; ea.st = 3'd1; ea.req = 1; ea.sz = 2'd2;
        for (int k = 0; k < 4; k++) cyc("to_wait", ea, ea, 1'b0);
        eb = ea;
        ea = '0; ea.st = 3'd6; ea.trap = 1; ea.cause = 2'd2;
        for (int k = 0; k < 4; k++) cyc("to_trap", ea, eb, 1'b0);
        do_reset();

        // reset while a store waits in MEM
        i_instruction = 32'h00508023;
        ea = '0; ea.st = 3'd1; ea.req = 1; ea.sz = 2'd2; ea.irw = 1;
        cyc("sr_fetch", ea, ea, 1'b1);
        ea = '0; ea.st = 3'd2;
        cyc("sr_decode", ea, ea, 1'b0);
        ea = exec_exp(3, 32'h00508023);
        cyc("sr_exec", ea, ea, 1'b0);
        ea = '0; ea.st = 3'd4; ea.req = 1; ea.we = 1;
        cyc("sr_mem", ea, ea, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        ea = '0;
        check("sr_async_a", 32'(obs_a), 32'(ea));
        check("sr_async_b", 32'(obs_b), 32'(ea));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check("sr_boot_a", 32'(obs_a), 32'(ea));
        check("sr_boot_b", 32'(obs_b), 32'(ea));
        ea.st = 3'd1; ea.req = 1; ea.sz = 2'd2;
        cyc("sr_refetch", ea, ea, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_mc_controller.md
Name: rv32_mc_controller

Overview:
Multi-cycle RV32I control unit. It is the sequential successor to the single-cycle combinational decoder and adds a Moore FSM, a ready-handshaked memory interface with timeout, and a trap state. It extends decode coverage to LUI, AUIPC, JAL, JALR and all six branches. It drives the shared datapath through PC, IR, register-file, ALU and memory enables, plus an externally held ALUOut register.

Parameters:
TIMEOUT_CYC, 255, consecutive cycles of mem_req high without i_mem_ready before a bus-timeout trap; 0 disables the timeout.
ILLEGAL_TRAP, 1, 1 = an illegal instruction enters TRAP; 0 = it retires as a NOP (PC+4, no writes).

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_instruction  input  32  IR contents, valid from DECODE onward
i_mem_ready  input  1  memory accepts/completes the current request this cycle
i_BrEq  input  1  comparator equal
i_BrLt  input  1  comparator less-than, signed or unsigned per BrUn
PCWrite  output  1  load PC
PCSel  output  1  0 = PC+4, 1 = ALUOut register
IRWrite  output  1  load IR from memory read data
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_size  output  2  0 byte, 1 half, 2 word
mem_unsigned  output  1  zero-extend load data
ImmSel  output  3  1 I, 2 S, 3 B, 4 U, 5 J, 0 none
BrUn  output  1  unsigned compare
ASel  output  1  0 rs1, 1 PC
BSel  output  1  0 rs2, 1 imm
ALUSel  output  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 passB
RegWEn  output  1  register-file write
WBSel  output  2  0 mem, 1 ALU, 2 PC+4
state  output  3  0 BOOT, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 TRAP
trap  output  1  high in TRAP
trap_cause  output  2  0 none, 1 illegal, 2 bus timeout; held until reset

Behaviour:
- Reset and outputs
  - Reset is asynchronous. While i_rst_n is low: state = BOOT, all outputs 0, timeout counter 0, taken flop 0, trap_cause 0.
  - BOOT always goes to FETCH on the next edge.
  - All outputs are Moore functions of state and the latched taken flop, except ALU/Imm/Br fields, which also decode i_instruction. Outputs not listed for a state are 0.
- FETCH
  - Drives mem_req=1, mem_we=0, mem_size=2.
  - When i_mem_ready=1: IRWrite=1 in that cycle, go to DECODE.
  - Otherwise hold all request attributes stable.
- DECODE
  - Classifies the instruction. Legal set: opcode[1:0]=11 plus LUI, AUIPC, JAL, JALR (funct3=0), BRANCH (funct3 not 010/011), LOAD (funct3 in 000, 001, 010, 100, 101), STORE (funct3 ≤ 010), OP-IMM (slli/srli/srai need bits[31:25] = 0000000 or 0100000 with bit30 only on srai), OP (funct7 0000000, or 0100000 only for add→sub and srl→sra).
  - Illegal: go to TRAP with cause 1 if ILLEGAL_TRAP=1, else go to WB as a NOP.
  - Legal: go to EXEC.
- EXEC (1 cycle; the datapath latches ALUOut at the end)
  - OP: ASel=0, BSel=0, ALUSel from funct3/bit30.
  - OP-IMM: BSel=1, ImmSel=1.
  - LOAD/STORE: add, BSel=1, ImmSel 1 or 2.
  - LUI: passB, ImmSel=4.
  - AUIPC: ASel=1, BSel=1, ImmSel=4, add.
  - JAL: ASel=1, BSel=1, ImmSel=5, add.
  - JALR: ASel=0, BSel=1, ImmSel=1, add. The ALUOut LSB is cleared by the datapath.
  - BRANCH: ASel=1, BSel=1, ImmSel=3, add. BrUn=1 for bltu/bgeu. Samples i_BrEq/i_BrLt into taken (beq Eq, bne !Eq, blt/bltu Lt, bge/bgeu !Lt).
  - Next state: LOAD/STORE → MEM, all others → WB.
- MEM
  - Drives mem_req=1, mem_we=STORE, mem_size=funct3[1:0], mem_unsigned=funct3[2].
  - Holds until i_mem_ready=1, then goes to WB.
- WB (1 cycle, always goes to FETCH)
  - PCWrite=1.
  - PCSel=1 for JAL/JALR, or for BRANCH with taken=1; else 0.
  - RegWEn=1 for OP/OP-IMM/LUI/AUIPC (WBSel 1), LOAD (WBSel 0), JAL/JALR (WBSel 2).
  - taken clears here.
- Minimum latencies
  - ALU/branch/jump instructions: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle adds one.
- Timeout
  - Counter of width clog2(TIMEOUT_CYC+1) increments each cycle mem_req=1 and i_mem_ready=0, and clears on handshake or on state change.
  - When it reaches TIMEOUT_CYC with ready still low: go to TRAP, cause 2.
  - If ready arrives in the cycle the limit is hit, ready wins.
  - With TIMEOUT_CYC=0 the counter is disabled.
- TRAP
  - Sticky. All enables and mem_req are 0, trap=1. Exit only via reset.
- Reset mid-operation
  - mem_req, RegWEn and PCWrite drop asynchronously with reset; no partial write is issued after release.

Test Plan:
1. add x3,x1,x2 (0x002081B3), i_mem_ready=1 → state 1,2,3,5,1. EXEC shows ALUSel=0, ASel=0, BSel=0. WB shows RegWEn=1, WBSel=1, PCWrite=1, PCSel=0.
2. lw x5,8(x1) (0x0080A283), ready low 3 cycles in MEM → mem_req=1, mem_we=0, mem_size=2 held 4 cycles, then WB with RegWEn=1, WBSel=0. Total 8 cycles.
3. beq with i_BrEq=1 → WB PCSel=1. bgeu with i_BrLt=1 → BrUn=1 in EXEC, WB PCSel=0. jal → WB WBSel=2, PCSel=1, RegWEn=1.
4. TIMEOUT_CYC=4, ready held 0 in FETCH → state=6, trap=1, trap_cause=2 after 4 wait cycles. Outputs stay 0 until i_rst_n low.
5. 0xFFFFFFFF with ILLEGAL_TRAP=1 → TRAP, cause 1 from DECODE. With ILLEGAL_TRAP=0 → DECODE→WB, PCWrite=1, PCSel=0, RegWEn=0.
6. sb in MEM with ready low, assert i_rst_n=0 → mem_req and mem_we go 0 immediately, state=0. After release: BOOT→FETCH, mem_we=0.
